// File: rtl/swap_datapath_pkg.sv
// Shared definitions for the swap controller and the swap datapath.
package swap_datapath_pkg;

  localparam int unsigned DW_DEFAULT = 8;
  localparam int unsigned AW_DEFAULT = 3;

  // Swap step encodings driven on sel by the swap controller.
  localparam logic [1:0] SEL_IDLE  = 2'd0;
  localparam logic [1:0] SEL_LOAD  = 2'd1;
  localparam logic [1:0] SEL_COPY  = 2'd2;
  localparam logic [1:0] SEL_STORE = 2'd3;

endpackage

// File: rtl/swap_regfile.sv
// Register-file storage: one write port, one registered host read port and two
// combinational peek ports used by the swap sequencing.
module swap_regfile
  import swap_datapath_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic [AW-1:0] peek_a_addr,
  output logic [DW-1:0] peek_a_data,
  input  logic [AW-1:0] peek_b_addr,
  output logic [DW-1:0] peek_b_data
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem [Depth];

  // Storage update and registered read; a same-cycle write yields the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
    end
  end

  assign peek_a_data = mem[peek_a_addr];
  assign peek_b_data = mem[peek_b_addr];

endmodule

// File: rtl/swap_datapath.sv
// Swap datapath: executes the three-step swap of two register-file entries
// through a temp register, handles abort/restore, and arbitrates host writes.
module swap_datapath
  import swap_datapath_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    sel,
  input  logic          w,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          wr_ack,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          seq_err
);

  logic [1:0]    prev_sel;
  // Set only after a step 1 or step 2 that really executed, so a legal-looking
  // transition following a sequence error never copies, stores or restores.
  logic          in_swap;
  logic [AW-1:0] la;
  logic [AW-1:0] lb;
  logic [DW-1:0] temp;

  logic          step_load;
  logic          step_copy;
  logic          step_store;
  logic          abort_load;
  logic          restore;
  logic          seq_bad;
  logic          host_ok;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] peek_a_data;
  logic [DW-1:0] peek_b_data;

  // Step decode from the current request and the previous step.
  always_comb begin
    step_load  = w && (sel == SEL_LOAD)  && (prev_sel == SEL_IDLE);
    step_copy  = w && (sel == SEL_COPY)  && (prev_sel == SEL_LOAD) && in_swap;
    step_store = w && (sel == SEL_STORE) && (prev_sel == SEL_COPY) && in_swap;
    abort_load = (sel == SEL_IDLE) && (prev_sel == SEL_LOAD) && in_swap;
    restore    = (sel == SEL_IDLE) && (prev_sel == SEL_COPY) && in_swap;
    seq_bad    = (sel != SEL_IDLE) && !(step_load || step_copy || step_store);
    busy       = (sel != SEL_IDLE) || restore;
    // An abort after step 1 pulses aborted next cycle, so a host write then is
    // dropped to keep wr_ack exclusive of the other pulses.
    host_ok    = wr_en && !busy && !abort_load;
  end

  // Single write port: swap steps and restore take priority over the host.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (step_copy) begin
      mem_we    = 1'b1;
      mem_waddr = la;
      mem_wdata = peek_b_data;
    end else if (step_store) begin
      mem_we    = 1'b1;
      mem_waddr = lb;
      mem_wdata = temp;
    end else if (restore) begin
      mem_we    = 1'b1;
      mem_waddr = la;
      mem_wdata = temp;
    end else if (host_ok) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
    end
  end

  // Swap state: step history, latched addresses and the temp value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_sel <= SEL_IDLE;
      in_swap  <= 1'b0;
      la       <= '0;
      lb       <= '0;
      temp     <= '0;
    end else begin
      prev_sel <= sel;
      in_swap  <= step_load || step_copy;
      if (step_load) begin
        la   <= addr_a;
        lb   <= addr_b;
        temp <= peek_a_data;
      end
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done    <= 1'b0;
      aborted <= 1'b0;
      seq_err <= 1'b0;
      wr_ack  <= 1'b0;
    end else begin
      done    <= step_store;
      aborted <= abort_load || restore;
      seq_err <= seq_bad;
      wr_ack  <= host_ok;
    end
  end

  swap_regfile #(
    .DW (DW),
    .AW (AW)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .we          (mem_we),
    .waddr       (mem_waddr),
    .wdata       (mem_wdata),
    .raddr       (rd_addr),
    .rdata       (rd_data),
    .peek_a_addr (addr_a),
    .peek_a_data (peek_a_data),
    .peek_b_addr (lb),
    .peek_b_data (peek_b_data)
  );

endmodule

// File: doc/swap_datapath.md
SWAP_DATAPATH -- requirements
Module: swap_datapath

Interface
REQ-001 Parameters: DW, default 8, data width; AW, default 3, address width (depth = 2**AW).
REQ-002 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- sel  in  2  swap step from the swap controller: 0 idle, 1 load temp, 2 copy B->A, 3 write temp->B.
- w  in  1  swap write qualifier from the controller; high whenever sel != 0.
- addr_a  in  AW  first swap address.
- addr_b  in  AW  second swap address.
- wr_en  in  1  host write request.
- wr_addr  in  AW  host write address.
- wr_data  in  DW  host write data.
- rd_addr  in  AW  host read address.
- rd_data  out  DW  registered read data.
- wr_ack  out  1  one-cycle pulse: host write committed.
- busy  out  1  combinational; swap step or restore active.
- done  out  1  one-cycle pulse: swap completed.
- aborted  out  1  one-cycle pulse: swap abandoned, memory consistent.
- seq_err  out  1  one-cycle pulse: illegal sel transition.

Function
REQ-003 Storage SHALL be 2**AW x DW registers plus one DW-bit temp register, plus latched addresses la, lb.
REQ-004 prev_sel SHALL register sel every cycle; legal transitions are 0->0, 0->1, 1->2, 2->3, 3->0, 1->0, 2->0.
REQ-005 Step 1 (sel=1, w=1, prev_sel=0): on the clock edge, la<=addr_a, lb<=addr_b, temp<=mem[addr_a].
REQ-006 Step 2 (sel=2, w=1, prev_sel=1): mem[la]<=mem[lb].
REQ-007 Step 3 (sel=3, w=1, prev_sel=2): mem[lb]<=temp; done SHALL pulse in the following cycle.
REQ-008 addr_a/addr_b changes after step 1 SHALL have no effect on the running swap.
REQ-009 addr_a==addr_b SHALL still run all steps, leave memory unchanged, and pulse done.
REQ-010 Back-to-back swaps (3->0->1 with swap held) SHALL each complete independently, one done per swap.
REQ-011 Abort after step 1 (prev_sel=1, sel=0): no memory write; aborted pulses the next cycle.
REQ-012 Abort after step 2 (prev_sel=2, sel=0): restore cycle, mem[la]<=temp; aborted pulses the next cycle.
REQ-013 Illegal transition or sel!=0 with w=0: no memory or temp write, seq_err pulses the next cycle, prev_sel updated.
REQ-014 busy = (sel!=0) OR restore cycle.
REQ-015 Host writes:
- wr_en accepted only when busy=0: mem[wr_addr]<=wr_data, wr_ack pulses the next cycle.
- wr_en while busy=1 SHALL be dropped, no wr_ack; swap steps always win.
REQ-016 Reads:
- rd_data<=mem[rd_addr] every cycle, one-cycle latency.
- A same-cycle write to rd_addr returns the old value.
REQ-017 done, aborted, seq_err and wr_ack SHALL be mutually exclusive in any one cycle.

Reset
REQ-018 On rst low, asynchronously, all of the following SHALL clear to 0, held while rst is low: mem, temp, la, lb, prev_sel, rd_data, wr_ack, done, aborted, seq_err.
REQ-019 Reset mid-swap SHALL discard the swap with no restore and no aborted pulse; the first cycle after release is idle.

Structure
REQ-020 The shared package SHALL hold the sel step encodings (SEL_IDLE=0, SEL_LOAD=1, SEL_COPY=2, SEL_STORE=3) and the DW/AW defaults, used by both the swap controller and this block.
REQ-021 The storage array with its one write port and registered read port SHALL be a sub-module named swap_regfile; step sequencing, temp and the pulses stay in swap_datapath.

Verification
REQ-022 Bench SHALL cover the following directed scenarios:
- Load mem[2]=0x11, mem[5]=0x22; addr_a=2, addr_b=5; sel 1,2,3,0 -> mem[2]=0x22, mem[5]=0x11, done pulses once.
- Same preload; sel 1,2,0 -> restore cycle, mem[2]=0x11, mem[5]=0x22, aborted pulses once, no done.
- sel 0->2 -> seq_err pulses, memory unchanged.
- wr_en (addr 4, 0x5A) during sel=2 -> dropped, no wr_ack; retried at idle -> wr_ack, rd_addr=4 returns 0x5A one cycle later.
- Swap held for two full cycles on addresses 1/6 -> two done pulses, original contents restored.
- rst low during sel=2 -> all memory 0, no pulses, busy=0 after release.
